issue_select_scheduler: RTL and testbench
=========================================

// Module: issue_select_scheduler
// PURPOSE
//  Select/issue controller between issue queue and functional units. Each cycle picks one ready
//  ALU entry and one ready MUL entry (round-robin), sequences the multi-cycle MUL unit, and drives
//  a single shared writeback/wakeup port (dest PRF tag) back to the queue.
// PARAMETERS
//  IQ_DEPTH  8  issue-queue entries (power of 2, >=2)
//  IDX_W     3  log2(IQ_DEPTH)
//  PRF_W     6  physical register tag width
//  MUL_LAT   3  MUL execute cycles; legal range 2..15
// PORTS
//  clk              in   1               clock, rising edge
//  reset            in   1               synchronous, active-high
//  flush            in   1               sync pipeline flush
//  iq_valid         in   IQ_DEPTH        entry occupied
//  iq_ready         in   IQ_DEPTH        both sources ready
//  iq_is_mul        in   IQ_DEPTH        1=MUL op, 0=ALU op
//  iq_dest          in   IQ_DEPTH*PRF_W  entry i dest tag at [i*PRF_W +: PRF_W]
//  alu_grant        out  IQ_DEPTH        comb one-hot; IQ frees entry at next edge
//  mul_grant        out  IQ_DEPTH        comb one-hot; IQ frees entry at next edge
//  alu_issue_valid  out  1               reg: ALU op in execute
//  alu_issue_idx    out  IDX_W           reg: granted entry index
//  mul_issue_valid  out  1               reg: 1-cycle pulse, MUL op started
//  mul_issue_idx    out  IDX_W           reg: granted entry index
//  mul_busy         out  1               MUL FSM in BUSY
//  wb_valid         out  1               reg: writeback/wakeup broadcast
//  wb_dest_prf      out  PRF_W           reg: broadcast tag
//  wb_is_mul        out  1               reg: 1=source is MUL
// BEHAVIOUR
//  Reset: all registered outputs 0, alu_ptr=mul_ptr=0, MUL FSM=IDLE, cnt=0.
//  Eligibility: ALU: valid&ready&~is_mul; MUL: valid&ready&is_mul.
//  Select: first eligible index scanning ptr, ptr+1, .. wrapping mod IQ_DEPTH. On grant,
//   ptr <= idx+1 (wraps IQ_DEPTH-1 -> 0); no grant -> ptr holds. Max one grant per FU per cycle.
//  ALU timing: grant cycle t -> alu_issue_valid/idx at t+1 -> wb_valid, wb_is_mul=0,
//   wb_dest_prf=dest latched at grant, at t+2.
//  MUL FSM: IDLE/BUSY/WB.
//   IDLE: mul grant allowed; on grant -> BUSY, cnt<=MUL_LAT-1, latch dest.
//   BUSY: mul_busy=1, no mul grant; cnt decrements; cnt==0 -> WB.
//   WB: wb_valid=1, wb_is_mul=1 this cycle; mul grant allowed (back-to-back):
//    grant -> BUSY reloaded, else -> IDLE.
//   Grant t -> mul_issue_valid t+1, BUSY t+1..t+MUL_LAT, WB t+MUL_LAT+1.
//  Writeback collision: ALU grant suppressed in any cycle where FSM=BUSY and cnt==1
//   (MUL owns wb port two cycles later). Eligible ALU entries wait; alu_ptr holds.
//  flush: grants forced 0 that cycle; next edge clears alu/mul_issue_valid, pending ALU wb,
//   FSM->IDLE, cnt=0; wb_valid=0 next cycle. Pointers NOT reset by flush.
//  reset dominates flush. Reset mid-MUL aborts op, no writeback.
//  No eligible entries -> grants 0, no state change except FSM progress.
// CONFIGURATION
//  SCHED_PERF_CNT_EN defined: adds outputs perf_issue_cnt[31:0] (+1 per grant, +2 if both
//   grant in one cycle) and perf_stall_cnt[31:0] (+1 per cycle an eligible ALU entry is
//   suppressed or an eligible MUL entry is blocked by BUSY); wrap at 2^32; cleared by reset
//   only. Undefined: ports and counters absent; no other behaviour change.
// TESTING
//  1 Reset: reset=1 2 cycles -> all outputs 0, no grants even with iq_valid=iq_ready=8'hFF.
//  2 Round-robin: entries 1,5 ALU ready, ptr=0 -> grant idx1; next cycle (entry1 freed) idx5;
//    wb_valid t+2 with iq_dest[1] (e.g. 10), then t+3 with iq_dest[5].
//  3 MUL latency: entry3 MUL dest=11, MUL_LAT=3, grant t -> mul_issue t+1, mul_busy t+1..t+3,
//    wb_valid=1 wb_is_mul=1 wb_dest_prf=11 at t+4; second MUL waiting granted at t+4 (WB).
//  4 Collision: MUL granted t, ALU entry ready from t+1 -> ALU grant at t+1,t+3 ok but blocked
//    at t+2 (cnt==1); exactly one wb per cycle, never dropped.
//  5 Flush: flush during BUSY -> FSM IDLE next cycle, no MUL wb, wb_valid=0; ptrs retained.
//  6 Wrap: only entry 7 eligible, ptr=7 -> grant 7, ptr->0; perf_issue_cnt +1 (if _EN).

Source files
------------

// File: rtl/issue_select_scheduler.sv
// issue_select_scheduler: round-robin ALU/MUL select, multi-cycle MUL sequencing and one shared
// writeback/wakeup port. Define SCHED_PERF_CNT_EN to add perf_issue_cnt / perf_stall_cnt outputs.
//
// state  | meaning
// S_IDLE | MUL unit free, MUL grant allowed
// S_BUSY | MUL executing, cnt counts down to 0, no MUL grant
// S_WB   | MUL result on writeback port, back-to-back MUL grant allowed
module issue_select_scheduler #(
    parameter int IQ_DEPTH = 8,
    parameter int IDX_W    = 3,
    parameter int PRF_W    = 6,
    parameter int MUL_LAT  = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic [IQ_DEPTH-1:0]       iq_valid,
    input  logic [IQ_DEPTH-1:0]       iq_ready,
    input  logic [IQ_DEPTH-1:0]       iq_is_mul,
    input  logic [IQ_DEPTH*PRF_W-1:0] iq_dest,
    output logic [IQ_DEPTH-1:0]       alu_grant,
    output logic [IQ_DEPTH-1:0]       mul_grant,
    output logic                      alu_issue_valid,
    output logic [IDX_W-1:0]          alu_issue_idx,
    output logic                      mul_issue_valid,
    output logic [IDX_W-1:0]          mul_issue_idx,
    output logic                      mul_busy,
    output logic                      wb_valid,
    output logic [PRF_W-1:0]          wb_dest_prf,
    output logic                      wb_is_mul
`ifdef SCHED_PERF_CNT_EN
    ,
    output logic [31:0]               perf_issue_cnt,
    output logic [31:0]               perf_stall_cnt
`endif
);
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_WB} mul_state_t;

    mul_state_t          state;
    logic [CNT_W-1:0]    cnt;
    logic [IDX_W-1:0]    alu_ptr, mul_ptr;
    logic [IDX_W-1:0]    alu_sel, mul_sel, alu_cand, mul_cand;
    logic                alu_found, mul_found;
    logic                alu_block, mul_allow, alu_fire, mul_fire;
    logic [IQ_DEPTH-1:0] alu_elig, mul_elig;
    logic [PRF_W-1:0]    alu_dest_q, mul_dest_q;

    always_comb begin
        alu_elig  = iq_valid & iq_ready & ~iq_is_mul;
        mul_elig  = iq_valid & iq_ready & iq_is_mul;
        alu_found = 1'b0;
        mul_found = 1'b0;
        alu_sel   = '0;
        mul_sel   = '0;
        alu_cand  = '0;
        mul_cand  = '0;
        for (int k = 0; k < IQ_DEPTH; k++) begin
            alu_cand = alu_ptr + IDX_W'(k);
            mul_cand = mul_ptr + IDX_W'(k);
            if (!alu_found && alu_elig[alu_cand]) begin
                alu_found = 1'b1;
                alu_sel   = alu_cand;
            end
            if (!mul_found && mul_elig[mul_cand]) begin
                mul_found = 1'b1;
                mul_sel   = mul_cand;
            end
        end
        // The last BUSY count before writeback reserves the port two cycles out for the MUL.
        alu_block = (state == S_BUSY) && (cnt == CNT_W'(1));
        mul_allow = (state != S_BUSY);
        alu_fire  = alu_found && !alu_block && !flush && !reset;
        mul_fire  = mul_found && mul_allow && !flush && !reset;
        alu_grant = alu_fire ? (IQ_DEPTH'(1) << alu_sel) : '0;
        mul_grant = mul_fire ? (IQ_DEPTH'(1) << mul_sel) : '0;
        mul_busy  = (state == S_BUSY);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= S_IDLE;
            cnt             <= '0;
            alu_ptr         <= '0;
            mul_ptr         <= '0;
            alu_dest_q      <= '0;
            mul_dest_q      <= '0;
            alu_issue_valid <= 1'b0;
            alu_issue_idx   <= '0;
            mul_issue_valid <= 1'b0;
            mul_issue_idx   <= '0;
            wb_valid        <= 1'b0;
            wb_dest_prf     <= '0;
            wb_is_mul       <= 1'b0;
        end else begin
            alu_issue_valid <= alu_fire;
            mul_issue_valid <= mul_fire;
            if (alu_fire) begin
                alu_ptr       <= alu_sel + IDX_W'(1);
                alu_issue_idx <= alu_sel;
                alu_dest_q    <= iq_dest[alu_sel*PRF_W +: PRF_W];
            end
            if (mul_fire) begin
                mul_ptr       <= mul_sel + IDX_W'(1);
                mul_issue_idx <= mul_sel;
                mul_dest_q    <= iq_dest[mul_sel*PRF_W +: PRF_W];
            end

            if (flush) begin
                wb_valid  <= 1'b0;
                wb_is_mul <= 1'b0;
            end else if (state == S_BUSY && cnt == '0) begin
                wb_valid    <= 1'b1;
                wb_is_mul   <= 1'b1;
                wb_dest_prf <= mul_dest_q;
            end else if (alu_issue_valid) begin
                wb_valid    <= 1'b1;
                wb_is_mul   <= 1'b0;
                wb_dest_prf <= alu_dest_q;
            end else begin
                wb_valid  <= 1'b0;
                wb_is_mul <= 1'b0;
            end

            if (flush) begin
                state <= S_IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    S_IDLE, S_WB: begin
                        if (mul_fire) begin
                            state <= S_BUSY;
                            cnt   <= CNT_W'(MUL_LAT - 1);
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                    S_BUSY: begin
                        if (cnt == '0) state <= S_WB;
                        else           cnt   <= cnt - CNT_W'(1);
                    end
                    default: begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

`ifdef SCHED_PERF_CNT_EN
    logic stall_evt;

    always_comb begin
        stall_evt = !flush && (((|alu_elig) && alu_block) || ((|mul_elig) && !mul_allow));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_issue_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            perf_issue_cnt <= perf_issue_cnt + 32'(alu_fire) + 32'(mul_fire);
            if (stall_evt) perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_issue_select_scheduler.sv
// Bench for issue_select_scheduler: directed scenarios plus a randomized run against a
// writeback-reservation-table reference model of the issue queue and function units.
module tb_issue_select_scheduler;
    localparam int D = 8;
    localparam int L = 3;

    logic         clk;
    logic         reset;
    logic         flush;
    logic [7:0]   iq_valid, iq_ready, iq_is_mul;
    logic [47:0]  iq_dest;
    logic [7:0]   alu_grant, mul_grant;
    logic         alu_issue_valid, mul_issue_valid, mul_busy;
    logic [2:0]   alu_issue_idx, mul_issue_idx;
    logic         wb_valid, wb_is_mul;
    logic [5:0]   wb_dest_prf;
`ifdef SCHED_PERF_CNT_EN
    logic [31:0]  perf_issue_cnt, perf_stall_cnt;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    issue_select_scheduler #(.IQ_DEPTH(8), .IDX_W(3), .PRF_W(6), .MUL_LAT(L)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .iq_valid(iq_valid), .iq_ready(iq_ready), .iq_is_mul(iq_is_mul), .iq_dest(iq_dest),
        .alu_grant(alu_grant), .mul_grant(mul_grant),
        .alu_issue_valid(alu_issue_valid), .alu_issue_idx(alu_issue_idx),
        .mul_issue_valid(mul_issue_valid), .mul_issue_idx(mul_issue_idx),
        .mul_busy(mul_busy), .wb_valid(wb_valid), .wb_dest_prf(wb_dest_prf), .wb_is_mul(wb_is_mul)
`ifdef SCHED_PERF_CNT_EN
        , .perf_issue_cnt(perf_issue_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_entry(input int i, input bit v, input bit r, input bit m, input logic [5:0] d);
        iq_valid[i]        = v;
        iq_ready[i]        = r;
        iq_is_mul[i]       = m;
        iq_dest[i*6 +: 6]  = d;
    endtask

    task automatic clear_iq();
        iq_valid  = '0;
        iq_ready  = '0;
        iq_is_mul = '0;
        iq_dest   = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        flush = 1'b0;
        clear_iq();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; flush = 1'b0;
        iq_valid = 8'hFF; iq_ready = 8'hFF; iq_is_mul = 8'h0F; iq_dest = 48'hFFFF_FFFF_FFFF;
        @(negedge clk);
        @(negedge clk);
        #1;
        n_chk++; if (alu_grant !== 8'h00) begin n_fail++; $display("FAIL reset_alu_grant got=%h exp=00", alu_grant); end
        n_chk++; if (mul_grant !== 8'h00) begin n_fail++; $display("FAIL reset_mul_grant got=%h exp=00", mul_grant); end
        n_chk++; if ({alu_issue_valid, alu_issue_idx, mul_issue_valid, mul_issue_idx} !== 8'h00) begin
            n_fail++; $display("FAIL reset_issue got=%b exp=0", {alu_issue_valid, alu_issue_idx, mul_issue_valid, mul_issue_idx}); end
        n_chk++; if ({mul_busy, wb_valid, wb_is_mul, wb_dest_prf} !== 9'h000) begin
            n_fail++; $display("FAIL reset_wb got=%b exp=0", {mul_busy, wb_valid, wb_is_mul, wb_dest_prf}); end
        reset = 1'b0;
        clear_iq();
    endtask

    task automatic test_round_robin();
        do_reset();
        set_entry(1, 1, 1, 0, 6'd10);
        set_entry(5, 1, 1, 0, 6'd20);
        #1;
        n_chk++; if (alu_grant !== 8'h02) begin n_fail++; $display("FAIL rr_grant1 got=%h exp=02", alu_grant); end
        n_chk++; if (mul_grant !== 8'h00) begin n_fail++; $display("FAIL rr_no_mul got=%h exp=00", mul_grant); end
        @(negedge clk); iq_valid[1] = 1'b0; #1;
        n_chk++; if (alu_grant !== 8'h20) begin n_fail++; $display("FAIL rr_grant5 got=%h exp=20", alu_grant); end
        n_chk++; if (alu_issue_valid !== 1'b1 || alu_issue_idx !== 3'd1) begin
            n_fail++; $display("FAIL rr_issue1 got=%b/%0d exp=1/1", alu_issue_valid, alu_issue_idx); end
        @(negedge clk); iq_valid[5] = 1'b0; #1;
        n_chk++; if (alu_issue_valid !== 1'b1 || alu_issue_idx !== 3'd5) begin
            n_fail++; $display("FAIL rr_issue5 got=%b/%0d exp=1/5", alu_issue_valid, alu_issue_idx); end
        n_chk++; if (wb_valid !== 1'b1 || wb_is_mul !== 1'b0 || wb_dest_prf !== 6'd10) begin
            n_fail++; $display("FAIL rr_wb1 got=%b/%b/%0d exp=1/0/10", wb_valid, wb_is_mul, wb_dest_prf); end
        @(negedge clk); #1;
        n_chk++; if (wb_valid !== 1'b1 || wb_is_mul !== 1'b0 || wb_dest_prf !== 6'd20) begin
            n_fail++; $display("FAIL rr_wb5 got=%b/%b/%0d exp=1/0/20", wb_valid, wb_is_mul, wb_dest_prf); end
        @(negedge clk); #1;
        n_chk++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL rr_wb_idle got=%b exp=0", wb_valid); end
    endtask

    task automatic test_mul_latency();
        do_reset();
        set_entry(3, 1, 1, 1, 6'd11);
        set_entry(6, 1, 1, 1, 6'd33);
        #1;
        n_chk++; if (mul_grant !== 8'h08) begin n_fail++; $display("FAIL mul_grant3 got=%h exp=08", mul_grant); end
        @(negedge clk); iq_valid[3] = 1'b0; #1;
        n_chk++; if (mul_issue_valid !== 1'b1 || mul_issue_idx !== 3'd3 || mul_busy !== 1'b1) begin
            n_fail++; $display("FAIL mul_issue got=%b/%0d/%b exp=1/3/1", mul_issue_valid, mul_issue_idx, mul_busy); end
        n_chk++; if (mul_grant !== 8'h00) begin n_fail++; $display("FAIL mul_busy_block got=%h exp=00", mul_grant); end
        for (int k = 2; k <= L; k++) begin
            @(negedge clk); #1;
            n_chk++; if (mul_busy !== 1'b1 || mul_issue_valid !== 1'b0 || mul_grant !== 8'h00 || wb_valid !== 1'b0) begin
                n_fail++; $display("FAIL mul_busy_t%0d got=%b/%b/%h/%b exp=1/0/00/0", k, mul_busy, mul_issue_valid, mul_grant, wb_valid); end
        end
        @(negedge clk); #1;
        n_chk++; if (wb_valid !== 1'b1 || wb_is_mul !== 1'b1 || wb_dest_prf !== 6'd11 || mul_busy !== 1'b0) begin
            n_fail++; $display("FAIL mul_wb got=%b/%b/%0d/%b exp=1/1/11/0", wb_valid, wb_is_mul, wb_dest_prf, mul_busy); end
        n_chk++; if (mul_grant !== 8'h40) begin n_fail++; $display("FAIL mul_b2b_grant got=%h exp=40", mul_grant); end
        @(negedge clk); iq_valid[6] = 1'b0; #1;
        n_chk++; if (mul_issue_valid !== 1'b1 || mul_issue_idx !== 3'd6 || mul_busy !== 1'b1 || wb_valid !== 1'b0) begin
            n_fail++; $display("FAIL mul_b2b_issue got=%b/%0d/%b/%b exp=1/6/1/0", mul_issue_valid, mul_issue_idx, mul_busy, wb_valid); end
        repeat (L) @(negedge clk);
        #1;
        n_chk++; if (wb_valid !== 1'b1 || wb_is_mul !== 1'b1 || wb_dest_prf !== 6'd33) begin
            n_fail++; $display("FAIL mul_b2b_wb got=%b/%b/%0d exp=1/1/33", wb_valid, wb_is_mul, wb_dest_prf); end
    endtask

    task automatic test_collision();
        do_reset();
        set_entry(0, 1, 1, 1, 6'd40);
        #1;
        n_chk++; if (mul_grant !== 8'h01 || alu_grant !== 8'h00) begin
            n_fail++; $display("FAIL col_mul_grant got=%h/%h exp=01/00", mul_grant, alu_grant); end
        @(negedge clk);
        iq_valid[0] = 1'b0;
        set_entry(2, 1, 1, 0, 6'd50);
        set_entry(4, 1, 1, 0, 6'd51);
        set_entry(5, 1, 1, 0, 6'd52);
        #1;
        n_chk++; if (alu_grant !== 8'h04) begin n_fail++; $display("FAIL col_alu_t1 got=%h exp=04", alu_grant); end
        @(negedge clk); iq_valid[2] = 1'b0; #1;
        n_chk++; if (alu_grant !== 8'h00) begin n_fail++; $display("FAIL col_alu_blocked got=%h exp=00", alu_grant); end
        @(negedge clk); #1;
        n_chk++; if (alu_grant !== 8'h10) begin n_fail++; $display("FAIL col_alu_t3 got=%h exp=10", alu_grant); end
        n_chk++; if (wb_valid !== 1'b1 || wb_is_mul !== 1'b0 || wb_dest_prf !== 6'd50) begin
            n_fail++; $display("FAIL col_wb_t3 got=%b/%b/%0d exp=1/0/50", wb_valid, wb_is_mul, wb_dest_prf); end
        @(negedge clk); iq_valid[4] = 1'b0; #1;
        n_chk++; if (alu_grant !== 8'h20) begin n_fail++; $display("FAIL col_alu_t4 got=%h exp=20", alu_grant); end
        n_chk++; if (wb_valid !== 1'b1 || wb_is_mul !== 1'b1 || wb_dest_prf !== 6'd40) begin
            n_fail++; $display("FAIL col_wb_t4 got=%b/%b/%0d exp=1/1/40", wb_valid, wb_is_mul, wb_dest_prf); end
        @(negedge clk); iq_valid[5] = 1'b0; #1;
        n_chk++; if (wb_valid !== 1'b1 || wb_is_mul !== 1'b0 || wb_dest_prf !== 6'd51) begin
            n_fail++; $display("FAIL col_wb_t5 got=%b/%b/%0d exp=1/0/51", wb_valid, wb_is_mul, wb_dest_prf); end
        @(negedge clk); #1;
        n_chk++; if (wb_valid !== 1'b1 || wb_is_mul !== 1'b0 || wb_dest_prf !== 6'd52) begin
            n_fail++; $display("FAIL col_wb_t6 got=%b/%b/%0d exp=1/0/52", wb_valid, wb_is_mul, wb_dest_prf); end
    endtask

    task automatic test_flush();
        do_reset();
        set_entry(1, 1, 1, 1, 6'd7);
        #1;
        n_chk++; if (mul_grant !== 8'h02) begin n_fail++; $display("FAIL fl_mul_grant got=%h exp=02", mul_grant); end
        @(negedge clk); iq_valid[1] = 1'b0; #1;
        n_chk++; if (mul_busy !== 1'b1) begin n_fail++; $display("FAIL fl_busy got=%b exp=1", mul_busy); end
        @(negedge clk);
        flush = 1'b1;
        set_entry(3, 1, 1, 0, 6'd9);
        #1;
        n_chk++; if (alu_grant !== 8'h00 || mul_grant !== 8'h00) begin
            n_fail++; $display("FAIL fl_grants_forced got=%h/%h exp=00/00", alu_grant, mul_grant); end
        @(negedge clk);
        flush = 1'b0;
        set_entry(0, 1, 1, 1, 6'd1);
        set_entry(4, 1, 1, 1, 6'd2);
        #1;
        n_chk++; if (mul_busy !== 1'b0 || wb_valid !== 1'b0 || alu_issue_valid !== 1'b0 || mul_issue_valid !== 1'b0) begin
            n_fail++; $display("FAIL fl_cleared got=%b/%b/%b/%b exp=0/0/0/0", mul_busy, wb_valid, alu_issue_valid, mul_issue_valid); end
        n_chk++; if (alu_grant !== 8'h08 || mul_grant !== 8'h10) begin
            n_fail++; $display("FAIL fl_ptr_kept got=%h/%h exp=08/10", alu_grant, mul_grant); end
        @(negedge clk); clear_iq(); #1;
        n_chk++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL fl_no_mul_wb got=%b exp=0", wb_valid); end
        @(negedge clk); #1;
        n_chk++; if (wb_valid !== 1'b1 || wb_is_mul !== 1'b0 || wb_dest_prf !== 6'd9) begin
            n_fail++; $display("FAIL fl_alu_wb got=%b/%b/%0d exp=1/0/9", wb_valid, wb_is_mul, wb_dest_prf); end
        @(negedge clk); @(negedge clk); #1;
        n_chk++; if (wb_valid !== 1'b1 || wb_is_mul !== 1'b1 || wb_dest_prf !== 6'd2) begin
            n_fail++; $display("FAIL fl_mul_wb got=%b/%b/%0d exp=1/1/2", wb_valid, wb_is_mul, wb_dest_prf); end
    endtask

    task automatic test_wrap();
        do_reset();
        set_entry(6, 1, 1, 0, 6'd16);
        #1;
        n_chk++; if (alu_grant !== 8'h40) begin n_fail++; $display("FAIL wrap_grant6 got=%h exp=40", alu_grant); end
        @(negedge clk);
        iq_valid[6] = 1'b0;
        set_entry(0, 1, 1, 0, 6'd20);
        set_entry(7, 1, 1, 0, 6'd27);
        #1;
        n_chk++; if (alu_grant !== 8'h80) begin n_fail++; $display("FAIL wrap_grant7 got=%h exp=80", alu_grant); end
        @(negedge clk);
        iq_valid[7] = 1'b0;
        set_entry(6, 1, 1, 0, 6'd26);
        #1;
        n_chk++; if (alu_grant !== 8'h01) begin n_fail++; $display("FAIL wrap_ptr0 got=%h exp=01", alu_grant); end
        @(negedge clk); clear_iq(); #1;
        n_chk++; if (alu_issue_idx !== 3'd0 || wb_valid !== 1'b1 || wb_dest_prf !== 6'd27) begin
            n_fail++; $display("FAIL wrap_wb got=%0d/%b/%0d exp=0/1/27", alu_issue_idx, wb_valid, wb_dest_prf); end
    endtask

    function automatic int rr_pick(input logic [7:0] elig, input int ptr);
        for (int k = 0; k < D; k++)
            if (elig[(ptr + k) % D]) return (ptr + k) % D;
        return -1;
    endfunction

    // Model: an issue queue, two round-robin pointers, and a table of which cycle owns the
    // writeback port. An ALU op may only issue if the slot two cycles ahead is still free.
    task automatic test_random();
        bit         m_v[D], m_r[D], m_m[D];
        logic [5:0] m_d[D];
        bit         wv[16], wm[16];
        logic [5:0] wd[16];
        int         aptr, mptr, mstart, ea, em, slot;
        bit         mactive, e_aiv, e_miv, busy, blocked;
        int         e_aidx, e_midx;
        logic [7:0] ael, mel, exp_ag, exp_mg;
        do_reset();
        aptr = 0; mptr = 0; mstart = 0; mactive = 0; e_aiv = 0; e_miv = 0; e_aidx = 0; e_midx = 0;
        for (int i = 0; i < D; i++) begin m_v[i] = 0; m_r[i] = 0; m_m[i] = 0; m_d[i] = '0; end
        for (int i = 0; i < 16; i++) begin wv[i] = 0; wm[i] = 0; wd[i] = '0; end
        for (int c = 0; c < 2000; c++) begin
            if (c != 0) @(negedge clk);
            for (int i = 0; i < D; i++) begin
                if (!m_v[i] && $urandom_range(2) == 0) begin
                    m_v[i] = 1; m_r[i] = 1'($urandom_range(1)); m_m[i] = 1'($urandom_range(1));
                    m_d[i] = 6'($urandom_range(63));
                end else if (m_v[i] && !m_r[i] && $urandom_range(1) == 1) begin
                    m_r[i] = 1;
                end
                set_entry(i, m_v[i], m_r[i], m_m[i], m_d[i]);
            end
            flush = ($urandom_range(39) == 0);
            #1;
            ael = '0; mel = '0;
            for (int i = 0; i < D; i++) begin
                ael[i] = m_v[i] & m_r[i] & ~m_m[i];
                mel[i] = m_v[i] & m_r[i] & m_m[i];
            end
            busy    = mactive && (c >= mstart + 1) && (c <= mstart + L);
            blocked = wv[(c + 2) % 16];
            ea = (flush || blocked) ? -1 : rr_pick(ael, aptr);
            em = (flush || busy) ? -1 : rr_pick(mel, mptr);
            exp_ag = (ea >= 0) ? (8'h01 << ea) : 8'h00;
            exp_mg = (em >= 0) ? (8'h01 << em) : 8'h00;
            slot = c % 16;
            n_chk++; if (alu_grant !== exp_ag) begin n_fail++; $display("FAIL rnd_alu_grant cyc=%0d got=%h exp=%h", c, alu_grant, exp_ag); end
            n_chk++; if (mul_grant !== exp_mg) begin n_fail++; $display("FAIL rnd_mul_grant cyc=%0d got=%h exp=%h", c, mul_grant, exp_mg); end
            n_chk++; if (mul_busy !== busy) begin n_fail++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", c, mul_busy, busy); end
            n_chk++; if (alu_issue_valid !== e_aiv || (e_aiv && alu_issue_idx !== 3'(e_aidx))) begin
                n_fail++; $display("FAIL rnd_alu_issue cyc=%0d got=%b/%0d exp=%b/%0d", c, alu_issue_valid, alu_issue_idx, e_aiv, e_aidx); end
            n_chk++; if (mul_issue_valid !== e_miv || (e_miv && mul_issue_idx !== 3'(e_midx))) begin
                n_fail++; $display("FAIL rnd_mul_issue cyc=%0d got=%b/%0d exp=%b/%0d", c, mul_issue_valid, mul_issue_idx, e_miv, e_midx); end
            n_chk++; if (wb_valid !== wv[slot] || (wv[slot] && (wb_is_mul !== wm[slot] || wb_dest_prf !== wd[slot]))) begin
                n_fail++; $display("FAIL rnd_wb cyc=%0d got=%b/%b/%0d exp=%b/%b/%0d", c, wb_valid, wb_is_mul, wb_dest_prf, wv[slot], wm[slot], wd[slot]); end
            wv[slot] = 0;
            if (flush) begin
                for (int i = 0; i < 16; i++) wv[i] = 0;
                mactive = 0; e_aiv = 0; e_miv = 0;
            end else begin
                e_aiv = (ea >= 0);
                e_miv = (em >= 0);
                if (ea >= 0) begin
                    wv[(c + 2) % 16] = 1; wm[(c + 2) % 16] = 0; wd[(c + 2) % 16] = m_d[ea];
                    aptr = (ea + 1) % D; e_aidx = ea; m_v[ea] = 0;
                end
                if (em >= 0) begin
                    wv[(c + L + 1) % 16] = 1; wm[(c + L + 1) % 16] = 1; wd[(c + L + 1) % 16] = m_d[em];
                    mptr = (em + 1) % D; e_midx = em; m_v[em] = 0;
                    mstart = c; mactive = 1;
                end
            end
        end
        @(negedge clk);
        flush = 1'b0;
        clear_iq();
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        clear_iq();
        test_reset();
        test_round_robin();
        test_mul_latency();
        test_collision();
        test_flush();
        test_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
